stopwatch_lap: RTL and testbench

Parametrised successor to the single-mode board stopwatch. Counts MM:SS.CC (minutes, seconds, hundredths) in BCD, up or down, with start/stop, clear, a down-count preset, and a lap-freeze display. It drives six active-low seven-segment digits on the DE-class board. It sits directly between the debounced KEY buttons and HEX0..HEX5.

---
 rtl/stopwatch_pkg.sv | 70 +++++++
 rtl/bcd_to_seg7.sv | 14 +
 rtl/stopwatch_lap.sv | 191 +++++++++++++++++++
 tb/tb_stopwatch_lap.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS.CC BCD stopwatch: FSM states,
// KEY bit positions, the active-low seven-segment glyph table and BCD step helpers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int KEY_STARTSTOP = 0;
    localparam int KEY_LAP       = 1;
    localparam int KEY_DIR       = 2;
    localparam int KEY_CLEAR     = 3;

    // Segment order gfedcba, active low; codes 10..15 are blanked.
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
    };
    localparam logic [6:0] SEG7_ZERO = 7'b1000000;

    typedef struct packed {
        logic [7:0] mins;
        logic [7:0] secs;
        logic [7:0] hund;
    } bcd_time_t;

    // One BCD digit pair stepped up or down; bit 8 is the carry/borrow out.
    function automatic logic [8:0] pair_step(input logic [7:0] v, input logic [3:0] tens_max,
                                             input logic down);
        logic [8:0] r;
        if (!down) begin
            if (v[3:0] != 4'd9) begin
                r = {1'b0, v[7:4], v[3:0] + 4'd1};
            end else if (v[7:4] != tens_max) begin
                r = {1'b0, v[7:4] + 4'd1, 4'd0};
            end else begin
                r = {1'b1, 8'h00};
            end
        end else begin
            if (v[3:0] != 4'd0) begin
                r = {1'b0, v[7:4], v[3:0] - 4'd1};
            end else if (v[7:4] != 4'd0) begin
                r = {1'b0, v[7:4] - 4'd1, 4'd9};
            end else begin
                r = {1'b1, tens_max, 4'd9};
            end
        end
        return r;
    endfunction

    function automatic bcd_time_t time_step(input bcd_time_t t, input logic down);
        logic [8:0] h;
        logic [8:0] s;
        logic [8:0] m;
        bcd_time_t  r;
        h = pair_step(t.hund, 4'd9, down);
        s = pair_step(t.secs, 4'd5, down);
        m = pair_step(t.mins, 4'd5, down);
        r.hund = h[7:0];
        r.secs = h[8] ? s[7:0] : t.secs;
        r.mins = (h[8] && s[8]) ? m[7:0] : t.mins;
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to an active-low seven-segment pattern; non-decimal codes blank the digit.
module bcd_to_seg7
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup, purely combinational; the parent registers the result.
    always_comb begin
        seg = SEG7_TABLE[bcd];
    end

endmodule

// File: rtl/stopwatch_lap.sv
// Up/down MM:SS.CC BCD stopwatch driving six active-low HEX digits from debounced KEYs.
// Define STOPWATCH_LAP_EN to build the lap-freeze display (KEY[1]); otherwise KEY[1] is ignored.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 100,
    parameter int PRESET_MIN = 1,
    parameter int PRESET_SEC = 0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       up,
    output logic       running,
    output logic       done
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [23:0] PRESET_BITS = {4'(PRESET_MIN / 10), 4'(PRESET_MIN % 10),
                                           4'(PRESET_SEC / 10), 4'(PRESET_SEC % 10), 8'h00};

    if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
        $error("stopwatch_lap: CLK_HZ must be a multiple of TICK_HZ with ratio >= 2");
    end
    if (PRESET_MIN < 0 || PRESET_MIN > 59 || PRESET_SEC < 0 || PRESET_SEC > 59) begin : g_bad_preset
        $error("stopwatch_lap: PRESET_MIN/PRESET_SEC must be in 0..59");
    end

    logic [3:0]      key_meta_q;
    logic [3:0]      key_sync_q;
    logic [3:0]      key_prev_q;
    logic [3:0]      key_fall_s;
    state_t          state_q, state_d;
    bcd_time_t       count_q, count_d;
    logic            up_q, up_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            running_q;
    logic            done_q;
    logic            tick_s;
    bcd_time_t       disp_s;
    logic [5:0][6:0] seg_s;
    logic [5:0][6:0] hex_q;
`ifdef STOPWATCH_LAP_EN
    logic            lap_q, lap_d;
    bcd_time_t       snap_q, snap_d;
`endif

    assign key_fall_s = key_prev_q & ~key_sync_q;
    assign tick_s     = (state_q == RUN) && (presc_q == PRESC_LAST);

    // Next-state: one key action per cycle by priority, then the tick in RUN.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        up_d    = up_q;
        presc_d = presc_q;
`ifdef STOPWATCH_LAP_EN
        lap_d   = lap_q;
        snap_d  = snap_q;
`endif
        if (key_fall_s[KEY_CLEAR]) begin
            state_d = IDLE;
            count_d = up_q ? 24'h000000 : PRESET_BITS;
            presc_d = {PW{1'b0}};
`ifdef STOPWATCH_LAP_EN
            lap_d   = 1'b0;
`endif
        end else if (key_fall_s[KEY_STARTSTOP]) begin
            // A stop press wins over a tick landing in the same cycle.
            case (state_q)
                IDLE, PAUSE: begin
                    state_d = RUN;
                    presc_d = {PW{1'b0}};
                end
                RUN:     state_d = PAUSE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end else begin
            if (key_fall_s[KEY_DIR]) begin
                if (state_q == IDLE || state_q == PAUSE) begin
                    up_d = ~up_q;
                end else begin
                    up_d = up_q;
                end
`ifdef STOPWATCH_LAP_EN
            end else if (key_fall_s[KEY_LAP] && (state_q == RUN || state_q == PAUSE)) begin
                lap_d  = ~lap_q;
                snap_d = lap_q ? snap_q : count_q;
`else
            end else if (key_fall_s[KEY_LAP]) begin
                up_d = up_q;
`endif
            end else begin
                up_d = up_q;
            end

            if (state_q == RUN) begin
                if (tick_s) begin
                    presc_d = {PW{1'b0}};
                    if (up_q) begin
                        count_d = time_step(count_q, 1'b0);
                    end else if (count_q == 24'h000000) begin
                        state_d = DONE;
                    end else begin
                        count_d = time_step(count_q, 1'b1);
                    end
                end else begin
                    presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
                end
            end else begin
                presc_d = presc_q;
            end
        end
    end

    // Display source: frozen snapshot while the lap flag is set.
    always_comb begin
`ifdef STOPWATCH_LAP_EN
        if (lap_q) begin
            disp_s = snap_q;
        end else begin
            disp_s = count_q;
        end
`else
        disp_s = count_q;
`endif
    end

    for (genvar k = 0; k < 6; k++) begin : g_digit
        bcd_to_seg7 u_seg (
            .bcd (disp_s[4*k +: 4]),
            .seg (seg_s[k])
        );
    end

    // All state, including the KEY synchronisers and the registered outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_meta_q <= 4'hF;
            key_sync_q <= 4'hF;
            key_prev_q <= 4'hF;
            state_q    <= IDLE;
            count_q    <= 24'h000000;
            up_q       <= 1'b1;
            presc_q    <= {PW{1'b0}};
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            hex_q      <= {6{SEG7_ZERO}};
`ifdef STOPWATCH_LAP_EN
            lap_q      <= 1'b0;
            snap_q     <= 24'h000000;
`endif
        end else begin
            key_meta_q <= KEY;
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
            state_q    <= state_d;
            count_q    <= count_d;
            up_q       <= up_d;
            presc_q    <= presc_d;
            running_q  <= (state_d == RUN);
            done_q     <= (state_d == DONE);
            hex_q      <= seg_s;
`ifdef STOPWATCH_LAP_EN
            lap_q      <= lap_d;
            snap_q     <= snap_d;
`endif
        end
    end

    assign HEX0    = hex_q[0];
    assign HEX1    = hex_q[1];
    assign HEX2    = hex_q[2];
    assign HEX3    = hex_q[3];
    assign HEX4    = hex_q[4];
    assign HEX5    = hex_q[5];
    assign up      = up_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: two instances (presets 00:01 and 59:59) share one KEY bus and are
// compared every cycle against an integer-centisecond reference model, plus fixed-value checkpoints.
module tb_stopwatch_lap;

    localparam int DIV     = 10;
    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_DONE = 3;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      key;
    logic [5:0][6:0] hx_a, hx_b;
    logic            up_a, run_a, done_a, up_b, run_b, done_b;

    int errors = 0;
    int checks = 0;

    int         m_st[2], m_cs[2], m_presc[2], m_snap[2], m_disp[2];
    bit         m_up[2], m_lap[2];
    logic [3:0] h1, h2, h3;

    always #5 clk = ~clk;

    stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .PRESET_MIN(0), .PRESET_SEC(1)) u_a (
        .CLOCK_50(clk), .reset(rst), .KEY(key),
        .HEX0(hx_a[0]), .HEX1(hx_a[1]), .HEX2(hx_a[2]), .HEX3(hx_a[3]), .HEX4(hx_a[4]), .HEX5(hx_a[5]),
        .up(up_a), .running(run_a), .done(done_a));

    stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .PRESET_MIN(59), .PRESET_SEC(59)) u_b (
        .CLOCK_50(clk), .reset(rst), .KEY(key),
        .HEX0(hx_b[0]), .HEX1(hx_b[1]), .HEX2(hx_b[2]), .HEX3(hx_b[3]), .HEX4(hx_b[4]), .HEX5(hx_b[5]),
        .up(up_b), .running(run_b), .done(done_b));

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] time_vec(input int mm, input int ss, input int cc);
        return {seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10), seg(cc / 10), seg(cc % 10)};
    endfunction

    function automatic int preset_cs(input int i);
        return (i == 0) ? 100 : (59 * 6000 + 59 * 100);
    endfunction

    function automatic logic [44:0] obs_vec(input int i);
        if (i == 0) return {hx_a, up_a, run_a, done_a};
        return {hx_b, up_b, run_b, done_b};
    endfunction

    function automatic logic [44:0] exp_vec(input int i);
        int t;
        t = m_disp[i];
        return {time_vec(t / 6000, (t / 100) % 60, t % 100), m_up[i],
                (m_st[i] == ST_RUN), (m_st[i] == ST_DONE)};
    endfunction

    task automatic model_reset();
        h1 = 4'hF; h2 = 4'hF; h3 = 4'hF;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = ST_IDLE; m_cs[i] = 0; m_presc[i] = 0; m_snap[i] = 0;
            m_disp[i] = 0; m_up[i] = 1'b1; m_lap[i] = 1'b0;
        end
    endtask

    // Reference behaviour for one clock edge, in whole centiseconds.
    task automatic model_edge();
        logic [3:0] fall;
        fall = h3 & ~h2;
        h3 = h2; h2 = h1; h1 = key;
        for (int i = 0; i < 2; i++) begin
            m_disp[i] = (LAP_ON && m_lap[i]) ? m_snap[i] : m_cs[i];
            if (fall[3]) begin
                m_st[i] = ST_IDLE; m_cs[i] = m_up[i] ? 0 : preset_cs(i);
                m_lap[i] = 1'b0; m_presc[i] = 0;
            end else if (fall[0]) begin
                if (m_st[i] == ST_IDLE || m_st[i] == ST_PAUSE) begin
                    m_st[i] = ST_RUN; m_presc[i] = 0;
                end else if (m_st[i] == ST_RUN) begin
                    m_st[i] = ST_PAUSE;
                end
            end else begin
                if (fall[2]) begin
                    if (m_st[i] == ST_IDLE || m_st[i] == ST_PAUSE) m_up[i] = !m_up[i];
                end else if (fall[1] && LAP_ON && (m_st[i] == ST_RUN || m_st[i] == ST_PAUSE)) begin
                    if (!m_lap[i]) m_snap[i] = m_cs[i];
                    m_lap[i] = !m_lap[i];
                end
                if (m_st[i] == ST_RUN) begin
                    if (m_presc[i] == DIV - 1) begin
                        m_presc[i] = 0;
                        if (m_up[i]) m_cs[i] = (m_cs[i] + 1) % 360000;
                        else if (m_cs[i] == 0) m_st[i] = ST_DONE;
                        else m_cs[i] = m_cs[i] - 1;
                    end else begin
                        m_presc[i] = m_presc[i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask);
        key = 4'hF ^ mask;
        repeat (3) step();
        key = 4'hF;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; key = 4'hF; model_reset();
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== {time_vec(0, 0, 0), 3'b100}) begin
                errors++; $display("FAIL reset dut=%0d got=%h want=%h", i, obs_vec(i), {time_vec(0, 0, 0), 3'b100});
            end
        end
        rst = 1'b0;
        repeat (5) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin errors++; $display("FAIL reset_idle dut=%0d got=%h want=%h", i, obs_vec(i), exp_vec(i)); end
            end
        end
    endtask

    task automatic test_start_count();
        press(4'b0001);
        checks++;
        if (run_a !== 1'b1) begin errors++; $display("FAIL start_running got=%b want=1", run_a); end
        repeat (1001) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin errors++; $display("FAIL start_live dut=%0d got=%h want=%h", i, obs_vec(i), exp_vec(i)); end
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== {time_vec(0, 1, 0), 3'b110}) begin
                errors++; $display("FAIL one_second dut=%0d got=%h want=%h", i, obs_vec(i), {time_vec(0, 1, 0), 3'b110});
            end
        end
    endtask

    task automatic test_down_done();
        press(4'b0001);
        press(4'b0100);
        checks++;
        if (up_a !== 1'b0 || obs_vec(0) !== exp_vec(0)) begin errors++; $display("FAIL dir_pause got=%h want=%h", obs_vec(0), exp_vec(0)); end
        press(4'b1000);
        checks++;
        if (obs_vec(0) !== {time_vec(0, 1, 0), 3'b000}) begin errors++; $display("FAIL preset_a got=%h want=%h", obs_vec(0), {time_vec(0, 1, 0), 3'b000}); end
        checks++;
        if (obs_vec(1) !== {time_vec(59, 59, 0), 3'b000}) begin errors++; $display("FAIL preset_b got=%h want=%h", obs_vec(1), {time_vec(59, 59, 0), 3'b000}); end
        press(4'b0001);
        repeat (1011) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin errors++; $display("FAIL down_live dut=%0d got=%h want=%h", i, obs_vec(i), exp_vec(i)); end
            end
        end
        checks++;
        if (obs_vec(0) !== {time_vec(0, 0, 0), 3'b001}) begin errors++; $display("FAIL done_reached got=%h want=%h", obs_vec(0), {time_vec(0, 0, 0), 3'b001}); end
        press(4'b0001);
        repeat (20) step();
        checks++;
        if (obs_vec(0) !== {time_vec(0, 0, 0), 3'b001} || obs_vec(1) !== exp_vec(1)) begin
            errors++; $display("FAIL done_ignores_start got=%h/%h want=%h/%h", obs_vec(0), obs_vec(1), {time_vec(0, 0, 0), 3'b001}, exp_vec(1));
        end
    endtask

    task automatic test_dir();
        press(4'b0001);
        press(4'b0100);
        checks++;
        if (up_a !== 1'b0 || up_b !== 1'b0 || run_b !== 1'b1) begin errors++; $display("FAIL dir_in_run got=%b%b%b want=001", up_a, up_b, run_b); end
        press(4'b1000);
        press(4'b0100);
        checks++;
        if (obs_vec(0) !== {time_vec(0, 1, 0), 3'b100}) begin errors++; $display("FAIL dir_idle_a got=%h want=%h", obs_vec(0), {time_vec(0, 1, 0), 3'b100}); end
        checks++;
        if (obs_vec(1) !== {time_vec(59, 59, 0), 3'b100}) begin errors++; $display("FAIL dir_idle_b got=%h want=%h", obs_vec(1), {time_vec(59, 59, 0), 3'b100}); end
    endtask

    task automatic test_wrap();
        press(4'b0001);
        repeat (991) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin errors++; $display("FAIL wrap_live dut=%0d got=%h want=%h", i, obs_vec(i), exp_vec(i)); end
            end
        end
        checks++;
        if (obs_vec(1) !== {time_vec(59, 59, 99), 3'b110}) begin errors++; $display("FAIL wrap_top got=%h want=%h", obs_vec(1), {time_vec(59, 59, 99), 3'b110}); end
        repeat (10) step();
        checks++;
        if (obs_vec(1) !== {time_vec(0, 0, 0), 3'b110}) begin errors++; $display("FAIL wrap_zero got=%h want=%h", obs_vec(1), {time_vec(0, 0, 0), 3'b110}); end
        checks++;
        if (obs_vec(0) !== {time_vec(0, 2, 0), 3'b110}) begin errors++; $display("FAIL wrap_a got=%h want=%h", obs_vec(0), {time_vec(0, 2, 0), 3'b110}); end
    endtask

    task automatic test_lap();
        logic [41:0] frozen;
        frozen = LAP_ON ? time_vec(0, 0, 50) : time_vec(0, 0, 79);
        press(4'b1000);
        press(4'b0001);
        repeat (500) step();
        press(4'b0010);
        repeat (292) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin errors++; $display("FAIL lap_live dut=%0d got=%h want=%h", i, obs_vec(i), exp_vec(i)); end
            end
        end
        checks++;
        if (obs_vec(0) !== {frozen, 3'b110}) begin errors++; $display("FAIL lap_frozen got=%h want=%h", obs_vec(0), {frozen, 3'b110}); end
        repeat (300) step();
        press(4'b0010);
        repeat (6) step();
        checks++;
        if (obs_vec(0) !== {time_vec(0, 1, 10), 3'b110}) begin errors++; $display("FAIL lap_release got=%h want=%h", obs_vec(0), {time_vec(0, 1, 10), 3'b110}); end
    endtask

    task automatic test_clear_start_same();
        press(4'b1001);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== {time_vec(0, 0, 0), 3'b100}) begin
                errors++; $display("FAIL clear_over_start dut=%0d got=%h want=%h", i, obs_vec(i), {time_vec(0, 0, 0), 3'b100});
            end
        end
        repeat (30) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin errors++; $display("FAIL clear_hold dut=%0d got=%h want=%h", i, obs_vec(i), exp_vec(i)); end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        press(4'b0001);
        repeat (237) step();
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== {time_vec(0, 0, 0), 3'b100}) begin
                errors++; $display("FAIL reset_mid_run dut=%0d got=%h want=%h", i, obs_vec(i), {time_vec(0, 0, 0), 3'b100});
            end
        end
        repeat (2) step();
        rst = 1'b0;
        repeat (20) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin errors++; $display("FAIL after_reset dut=%0d got=%h want=%h", i, obs_vec(i), exp_vec(i)); end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] mask;
        int         hold;
        int         gap;
        for (int n = 0; n < 30; n++) begin
            mask = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) mask = mask | (4'b0001 << $urandom_range(0, 3));
            hold = $urandom_range(1, 4);
            gap  = $urandom_range(2, 250);
            key  = 4'hF ^ mask;
            repeat (hold) step();
            key = 4'hF;
            repeat (gap) begin
                step();
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (obs_vec(i) !== exp_vec(i)) begin errors++; $display("FAIL random dut=%0d press=%0d got=%h want=%h", i, n, obs_vec(i), exp_vec(i)); end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        key = 4'hF;
        test_reset();
        test_start_count();
        test_down_done();
        test_dir();
        test_wrap();
        test_lap();
        test_clear_start_same();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
